fp_toplama_besleyici: RTL and testbench

FP_TOPLAMA_BESLEYICI -- requirements
Module: fp_toplama_besleyici

---
 rtl/fp_toplama_besleyici_if.sv | 23 ++
 rtl/fp_toplama_besleyici.sv | 123 ++++++++++++
 tb/tb_fp_toplama_besleyici.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_toplama_besleyici_if.sv
// Operand-pair input stream and result output stream of the FP adder feeder.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1; valid holds its data until then.
interface fp_toplama_besleyici_if #(
    parameter int b = 32
);
    logic         giris_gecerli_i;
    logic         giris_hazir_o;
    logic [b-1:0] a_i;
    logic [b-1:0] b_i;
    logic [b-1:0] sonuc_o;
    logic         sonuc_gecerli_o;
    logic         sonuc_hazir_i;

    modport master (
        output giris_gecerli_i, a_i, b_i, sonuc_hazir_i,
        input  giris_hazir_o, sonuc_o, sonuc_gecerli_o
    );

    modport slave (
        input  giris_gecerli_i, a_i, b_i, sonuc_hazir_i,
        output giris_hazir_o, sonuc_o, sonuc_gecerli_o
    );
endinterface

// File: rtl/fp_toplama_besleyici.sv
// Queues operand pairs and feeds them one at a time to a fixed-latency FP adder,
// holding the enable for GECIKME cycles and presenting the captured sum on a valid/ready output.
module fp_toplama_besleyici #(
    parameter int b        = 32,
    parameter int DERINLIK = 4,
    parameter int GECIKME  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    fp_toplama_besleyici_if.slave         bus,
    output logic [b-1:0]                  g1_o,
    output logic [b-1:0]                  g2_o,
    output logic                          en_o,
    input  logic [b-1:0]                  toplam_i,
    output logic                          dolu_o,
    output logic                          bos_o,
    output logic [$clog2(DERINLIK):0]     sayi_o,
    output logic [15:0]                   islem_o,
    output logic [1:0]                    durum_o
);
    localparam int AW   = $clog2(DERINLIK);
    localparam int CNTW = $clog2(GECIKME);

    typedef enum logic [1:0] {BOSTA = 2'd0, CALIS = 2'd1, CIKIS = 2'd2} durum_t;

    durum_t              durum_q, durum_d;
    logic [2*b-1:0]      bellek [DERINLIK];
    logic [AW-1:0]       yaz_ptr, oku_ptr;
    logic [AW:0]         sayi_q;
    logic [CNTW-1:0]     sayac_q;
    logic                push, pop, yukle;
    logic                sonuc_gecerli_q;
    logic [b-1:0]        sonuc_q;

    assign dolu_o              = (sayi_q == (AW+1)'(DERINLIK));
    assign bos_o               = (sayi_q == '0);
    assign sayi_o              = sayi_q;
    assign bus.giris_hazir_o   = !dolu_o;
    assign bus.sonuc_o         = sonuc_q;
    assign bus.sonuc_gecerli_o = sonuc_gecerli_q;
    assign durum_o             = durum_q;
    assign push                = bus.giris_gecerli_i && !dolu_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            bellek[yaz_ptr] <= {bus.a_i, bus.b_i};
        end
    end

    // Pointers wrap naturally because DERINLIK is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayi_q  <= '0;
        end else begin
            if (push) yaz_ptr <= yaz_ptr + 1'b1;
            if (pop)  oku_ptr <= oku_ptr + 1'b1;
            case ({push, pop})
                2'b10:   sayi_q <= sayi_q + 1'b1;
                2'b01:   sayi_q <= sayi_q - 1'b1;
                default: sayi_q <= sayi_q;
            endcase
        end
    end

    always_comb begin
        durum_d = durum_q;
        pop     = 1'b0;
        yukle   = 1'b0;
        case (durum_q)
            BOSTA: begin
                if (!bos_o) begin
                    pop     = 1'b1;
                    durum_d = CALIS;
                end
            end
            CALIS: begin
                if (sayac_q == CNTW'(GECIKME-1)) begin
                    yukle   = 1'b1;
                    durum_d = CIKIS;
                end
            end
            CIKIS: begin
                if (bus.sonuc_hazir_i) durum_d = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    // CIKIS always lasts at least one cycle, giving the adder two idle enable cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            durum_q         <= BOSTA;
            sayac_q         <= '0;
            en_o            <= 1'b0;
            g1_o            <= '0;
            g2_o            <= '0;
            sonuc_q         <= '0;
            sonuc_gecerli_q <= 1'b0;
            islem_o         <= '0;
        end else begin
            durum_q <= durum_d;
            if (pop) begin
                {g1_o, g2_o} <= bellek[oku_ptr];
                sayac_q      <= '0;
                en_o         <= 1'b1;
            end
            if (durum_q == CALIS && !yukle) begin
                sayac_q <= sayac_q + 1'b1;
            end
            if (yukle) begin
                sonuc_q         <= toplam_i;
                sonuc_gecerli_q <= 1'b1;
                en_o            <= 1'b0;
                islem_o         <= islem_o + 16'd1;
            end
            if (durum_q == CIKIS && bus.sonuc_hazir_i) begin
                sonuc_gecerli_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_toplama_besleyici.sv
// Bench for fp_toplama_besleyici: transaction-level reference model compared every cycle,
// an adder model that only yields a correct sum after GECIKME-1 enabled cycles, and directed scenarios.
module tb_fp_toplama_besleyici;
    localparam int B  = 32;
    localparam int D  = 4;
    localparam int G  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk, rst_n;
    logic [B-1:0]  g1, g2, toplam;
    logic          en, dolu, bos;
    logic [CW-1:0] sayi;
    logic [15:0]   islem;
    logic [1:0]    durum;

    fp_toplama_besleyici_if #(.b(B)) bus();

    fp_toplama_besleyici #(.b(B), .DERINLIK(D), .GECIKME(G)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .g1_o(g1), .g2_o(g2), .en_o(en), .toplam_i(toplam),
        .dolu_o(dolu), .bos_o(bos), .sayi_o(sayi), .islem_o(islem), .durum_o(durum)
    );

    int n_cmp = 0;
    int n_err = 0;
    int res_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real from_fp(input logic [31:0] x);
        int  e;
        real r;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        r = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -r : r;
    endfunction

    function automatic logic [31:0] to_fp(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        return to_fp(from_fp(x) + from_fp(y));
    endfunction

    // Adder model: output is garbage until the enable has been seen for GECIKME-1 edges.
    int acnt;
    always @(posedge clk) begin
        if (!rst_n || !en) acnt <= 0;
        else               acnt <= acnt + 1;
    end
    assign toplam = (acnt >= G - 1) ? fp_add(g1, g2) : 32'hFFFF_FFFF;

    // Reference model: pending-pair queue, one operation in flight, result held until taken.
    logic [63:0] m_q[$];
    logic [31:0] exp_q[$];
    int          m_faz;      // 0 idle, 1 adder running, 2 result waiting
    int          m_kalan;
    logic [31:0] m_g1, m_g2, m_sonuc;
    logic        m_gecerli, m_push, m_pop;
    logic [15:0] m_islem;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_q.delete();
                exp_q.delete();
                m_faz = 0; m_kalan = 0;
                m_g1 = '0; m_g2 = '0; m_sonuc = '0;
                m_gecerli = 1'b0; m_islem = '0;
            end else begin
                m_push = bus.giris_gecerli_i && (m_q.size() < D);
                m_pop  = (m_faz == 0) && (m_q.size() > 0);
                if (m_faz == 2 && bus.sonuc_hazir_i) begin
                    m_faz = 0;
                    m_gecerli = 1'b0;
                end else if (m_faz == 1) begin
                    m_kalan--;
                    if (m_kalan == 0) begin
                        m_sonuc   = fp_add(m_g1, m_g2);
                        m_gecerli = 1'b1;
                        m_islem++;
                        m_faz = 2;
                    end
                end
                if (m_pop) begin
                    {m_g1, m_g2} = m_q.pop_front();
                    m_faz   = 1;
                    m_kalan = G;
                end
                if (m_push) begin
                    m_q.push_back({bus.a_i, bus.b_i});
                    exp_q.push_back(fp_add(bus.a_i, bus.b_i));
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("sayi", 64'(sayi), 64'(m_q.size()));
            chk("bos", 64'(bos), 64'(m_q.size() == 0));
            chk("dolu", 64'(dolu), 64'(m_q.size() == D));
            chk("giris_hazir", 64'(bus.giris_hazir_o), 64'(m_q.size() < D));
            chk("en", 64'(en), 64'(m_faz == 1));
            chk("g1", 64'(g1), 64'(m_g1));
            chk("g2", 64'(g2), 64'(m_g2));
            chk("sonuc_gecerli", 64'(bus.sonuc_gecerli_o), 64'(m_gecerli));
            chk("islem", 64'(islem), 64'(m_islem));
            if (m_gecerli) chk("sonuc", 64'(bus.sonuc_o), 64'(m_sonuc));
            if (rst_n && bus.sonuc_gecerli_o && bus.sonuc_hazir_i) begin
                if (exp_q.size() == 0) chk("sonuc_fazla", 64'(bus.sonuc_o), 64'hFFFF_FFFF_FFFF_FFFF);
                else                   chk("sonuc_sira", 64'(bus.sonuc_o), 64'(exp_q.pop_front()));
                res_cnt++;
            end
        end
    end

    task automatic tik();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] x, input logic [31:0] y);
        logic hazir;
        bit   ok;
        ok = 1'b0;
        bus.giris_gecerli_i = 1'b1;
        bus.a_i = x;
        bus.b_i = y;
        for (int i = 0; i < 60; i++) begin
            hazir = bus.giris_hazir_o;
            tik();
            if (hazir) begin
                ok = 1'b1;
                break;
            end
        end
        bus.giris_gecerli_i = 1'b0;
        chk("push_sure", 64'(ok), 64'd1);
    endtask

    task automatic bosalt(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tik();
            if (bos && !en && !bus.sonuc_gecerli_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bosalt_sure", 64'(ok), 64'd1);
    endtask

    initial begin
        bit ok;
        int vcnt;
        rst_n = 1'b0;
        bus.giris_gecerli_i = 1'b0;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.sonuc_hazir_i = 1'b0;

        chk("model_1p2", 64'(fp_add(32'h3F80_0000, 32'h4000_0000)), 64'h4040_0000);
        chk("model_3p1", 64'(fp_add(32'h4040_0000, 32'h3F80_0000)), 64'h4080_0000);
        chk("model_15p15", 64'(fp_add(32'h3FC0_0000, 32'h3FC0_0000)), 64'h4040_0000);

        repeat (2) tik();
        chk("rst_sayi", 64'(sayi), 64'd0);
        chk("rst_bos", 64'(bos), 64'd1);
        chk("rst_dolu", 64'(dolu), 64'd0);
        chk("rst_hazir", 64'(bus.giris_hazir_o), 64'd1);
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_gecerli", 64'(bus.sonuc_gecerli_o), 64'd0);
        chk("rst_islem", 64'(islem), 64'd0);
        chk("rst_g1", 64'(g1), 64'd0);
        rst_n = 1'b1;
        tik();

        // Single operation: 1.0 + 2.0
        bus.giris_gecerli_i = 1'b1;
        bus.a_i = 32'h3F80_0000;
        bus.b_i = 32'h4000_0000;
        tik();
        bus.giris_gecerli_i = 1'b0;
        chk("t1_en_e0", 64'(en), 64'd0);
        chk("t1_sayi_e0", 64'(sayi), 64'd1);
        for (int k = 1; k <= G; k++) begin
            tik();
            chk("t1_en_high", 64'(en), 64'd1);
        end
        tik();
        chk("t1_en_e9", 64'(en), 64'd0);
        chk("t1_gecerli_e9", 64'(bus.sonuc_gecerli_o), 64'd1);
        chk("t1_sonuc_e9", 64'(bus.sonuc_o), 64'h4040_0000);
        chk("t1_islem", 64'(islem), 64'd1);

        // Back-pressure with one pair queued: 4.0 + 1.0
        bus.giris_gecerli_i = 1'b1;
        bus.a_i = 32'h4080_0000;
        bus.b_i = 32'h3F80_0000;
        tik();
        bus.giris_gecerli_i = 1'b0;
        for (int k = 0; k < 19; k++) begin
            tik();
            chk("t2_en_tut", 64'(en), 64'd0);
            chk("t2_sonuc_tut", 64'(bus.sonuc_o), 64'h4040_0000);
            chk("t2_sayi_tut", 64'(sayi), 64'd1);
        end
        bus.sonuc_hazir_i = 1'b1;
        tik();
        bus.sonuc_hazir_i = 1'b0;
        chk("t2_gecerli_dus", 64'(bus.sonuc_gecerli_o), 64'd0);
        chk("t2_en_h", 64'(en), 64'd0);
        tik();
        chk("t2_en_pop", 64'(en), 64'd1);
        chk("t2_g1_pop", 64'(g1), 64'h4080_0000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tik();
            if (bus.sonuc_gecerli_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t2_sonuc_sure", 64'(ok), 64'd1);
        chk("t2_sonuc", 64'(bus.sonuc_o), 64'h40A0_0000);

        // Simultaneous push and pop with two pairs queued
        push_pair(32'h3FC0_0000, 32'h3FC0_0000);
        push_pair(32'h4000_0000, 32'h4000_0000);
        chk("t3_sayi_once", 64'(sayi), 64'd2);
        bus.sonuc_hazir_i = 1'b1;
        tik();
        bus.giris_gecerli_i = 1'b1;
        bus.a_i = 32'h3F00_0000;
        bus.b_i = 32'h3E80_0000;
        tik();
        bus.giris_gecerli_i = 1'b0;
        chk("t3_sayi_ayni", 64'(sayi), 64'd2);
        chk("t3_en", 64'(en), 64'd1);
        chk("t3_g1", 64'(g1), 64'h3FC0_0000);
        bosalt(150);

        // Fill: six back-to-back pairs with the consumer stalled
        bus.sonuc_hazir_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.giris_gecerli_i = 1'b1;
            bus.a_i = to_fp(real'(i + 1));
            bus.b_i = 32'h3F80_0000;
            tik();
        end
        bus.giris_gecerli_i = 1'b0;
        chk("t4_dolu", 64'(dolu), 64'd1);
        chk("t4_sayi", 64'(sayi), 64'd4);
        chk("t4_hazir", 64'(bus.giris_hazir_o), 64'd0);
        bus.sonuc_hazir_i = 1'b1;
        bosalt(200);

        // Wrap: ten pairs streamed after a fresh reset
        rst_n = 1'b0;
        tik();
        rst_n = 1'b1;
        res_cnt = 0;
        tik();
        bus.sonuc_hazir_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_pair(to_fp(real'(i + 1)), to_fp(real'(i) * 0.25));
        end
        bosalt(200);
        chk("t5_sonuc_adet", 64'(res_cnt), 64'd10);
        chk("t5_islem", 64'(islem), 64'd10);

        // Reset in the middle of an operation with two pairs queued
        bus.sonuc_hazir_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.giris_gecerli_i = 1'b1;
            bus.a_i = to_fp(real'(i + 10));
            bus.b_i = 32'h4000_0000;
            tik();
        end
        bus.giris_gecerli_i = 1'b0;
        chk("t6_sayi_once", 64'(sayi), 64'd2);
        tik();
        tik();
        rst_n = 1'b0;
        tik();
        rst_n = 1'b1;
        chk("t6_en", 64'(en), 64'd0);
        chk("t6_sayi", 64'(sayi), 64'd0);
        chk("t6_bos", 64'(bos), 64'd1);
        chk("t6_gecerli", 64'(bus.sonuc_gecerli_o), 64'd0);
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tik();
            if (bus.sonuc_gecerli_o || en) vcnt++;
        end
        chk("t6_sessiz", 64'(vcnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
